// File: rtl/mem_watch_monitor.sv
// Snoops a data-memory write port and captures writes to a window of watched words.
// Stops capturing once the processor PC has stayed unchanged for P_HALT_CYC compares.
//
// state  | meaning
// IDLE   | waiting for i_arm; writes ignored
// RUN    | capturing watched writes, counting cycles, watching for PC stall
// HALTED | PC stall detected; captures frozen until re-armed
module mem_watch_monitor #(
  parameter int P_DATA_W    = 32,
  parameter int P_NUM_CH    = 4,
  parameter int P_BASE_WORD = 50,
  parameter int P_CNT_W     = 16,
  parameter int P_HALT_CYC  = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_arm,
  input  logic                         i_clear,
  input  logic                         i_mem_we,
  input  logic [P_DATA_W-1:0]          i_mem_addr,
  input  logic [P_DATA_W-1:0]          i_mem_wdata,
  input  logic [P_DATA_W-1:0]          i_pc,
  input  logic [3:0]                   i_sel,
  output logic [P_NUM_CH*P_DATA_W-1:0] o_ch_data,
  output logic [P_NUM_CH-1:0]          o_ch_valid,
  output logic [P_NUM_CH*P_CNT_W-1:0]  o_ch_wcnt,
  output logic [P_DATA_W-1:0]          o_sel_data,
  output logic [31:0]                  o_cycle_cnt,
  output logic [1:0]                   o_state,
  output logic                         o_halted
);

  localparam int LP_WORD_W  = P_DATA_W - 2;
  localparam int LP_STALL_W = $clog2(P_HALT_CYC);
  localparam logic [LP_STALL_W-1:0] LP_STALL_TC = LP_STALL_W'(P_HALT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_HALTED = 2'b10
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [P_DATA_W-1:0]     r_ch_data [P_NUM_CH];
  logic [P_CNT_W-1:0]      r_ch_wcnt [P_NUM_CH];
  logic [P_NUM_CH-1:0]     r_ch_valid;
  logic [31:0]             r_cycle_cnt;
  logic [P_DATA_W-1:0]     r_prev_pc;
  logic [LP_STALL_W-1:0]   r_stall_cnt;

  logic                    w_pc_same;
  logic                    w_halt;
  logic [P_NUM_CH-1:0]     w_hit;
  logic [LP_WORD_W-1:0]    w_word;
  logic [1:0]              w_unused_addr;

  // Byte-lane bits do not select a word
  assign w_word        = i_mem_addr[P_DATA_W-1:2];
  assign w_unused_addr = i_mem_addr[1:0];

  assign w_pc_same = (i_pc == r_prev_pc);
  assign w_halt    = (r_state == S_RUN) && w_pc_same && (r_stall_cnt == LP_STALL_TC);

  always_comb begin
    w_hit = '0;
    for (int k = 0; k < P_NUM_CH; k++) begin
      w_hit[k] = (r_state == S_RUN) && i_mem_we &&
                 (w_word == LP_WORD_W'(P_BASE_WORD + k));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_arm)  w_state_nxt = S_RUN;
      S_RUN:    if (w_halt) w_state_nxt = S_HALTED;
      S_HALTED: if (i_arm)  w_state_nxt = S_RUN;
      default:              w_state_nxt = S_IDLE;
    endcase
    if (i_clear) w_state_nxt = S_IDLE;
  end

  // Clear has the same effect as reset and overrides a simultaneous arm
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_state     <= S_IDLE;
      r_ch_valid  <= '0;
      r_cycle_cnt <= '0;
      r_prev_pc   <= '0;
      r_stall_cnt <= '0;
      for (int k = 0; k < P_NUM_CH; k++) begin
        r_ch_data[k] <= '0;
        r_ch_wcnt[k] <= '0;
      end
    end else begin
      r_state   <= w_state_nxt;
      r_prev_pc <= i_pc;

      if ((r_state == S_RUN) && w_pc_same && !w_halt)
        r_stall_cnt <= r_stall_cnt + LP_STALL_W'(1);
      else
        r_stall_cnt <= '0;

      if ((r_state == S_RUN) && (r_cycle_cnt != 32'hFFFF_FFFF))
        r_cycle_cnt <= r_cycle_cnt + 32'd1;

      for (int k = 0; k < P_NUM_CH; k++) begin
        if (w_hit[k]) begin
          r_ch_data[k]  <= i_mem_wdata;
          r_ch_valid[k] <= 1'b1;
          if (r_ch_wcnt[k] != '1)
            r_ch_wcnt[k] <= r_ch_wcnt[k] + P_CNT_W'(1);
        end
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < P_NUM_CH; g++) begin : g_pack
      assign o_ch_data[g*P_DATA_W +: P_DATA_W] = r_ch_data[g];
      assign o_ch_wcnt[g*P_CNT_W +: P_CNT_W]   = r_ch_wcnt[g];
    end
  endgenerate

  always_comb begin
    o_sel_data = '0;
    for (int k = 0; k < P_NUM_CH; k++) begin
      if (i_sel == 4'(k)) o_sel_data = r_ch_data[k];
    end
  end

  assign o_ch_valid  = r_ch_valid;
  assign o_cycle_cnt = r_cycle_cnt;
  assign o_state     = r_state;
  assign o_halted    = (r_state == S_HALTED);

endmodule

// File: tb/tb_mem_watch_monitor.sv
// Directed bench for mem_watch_monitor: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_mem_watch_monitor;
  localparam int DW  = 32;
  localparam int NCH = 4;
  localparam int CW  = 3;

  localparam int F_STATE  = 0;
  localparam int F_HALTED = 1;
  localparam int F_VALID  = 2;
  localparam int F_DATA   = 3;
  localparam int F_WCNT   = 4;
  localparam int F_SEL    = 5;
  localparam int F_CYC    = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              arm = 1'b0;
  logic              clear = 1'b0;
  logic              mem_we = 1'b0;
  logic [DW-1:0]     mem_addr = '0;
  logic [DW-1:0]     mem_wdata = '0;
  logic [DW-1:0]     pc = '0;
  logic [3:0]        sel = '0;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_valid;
  logic [NCH*CW-1:0] ch_wcnt;
  logic [DW-1:0]     sel_data;
  logic [31:0]       cycle_cnt;
  logic [1:0]        state;
  logic              halted;

  logic [DW-1:0]     pc_val = 32'h1000;
  logic              pc_hold = 1'b0;

  typedef struct {
    string       name;
    int          f;
    int          idx;
    logic [31:0] v;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  mem_watch_monitor #(
    .P_DATA_W(DW), .P_NUM_CH(NCH), .P_BASE_WORD(50), .P_CNT_W(CW), .P_HALT_CYC(8)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_arm(arm), .i_clear(clear),
    .i_mem_we(mem_we), .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata),
    .i_pc(pc), .i_sel(sel),
    .o_ch_data(ch_data), .o_ch_valid(ch_valid), .o_ch_wcnt(ch_wcnt),
    .o_sel_data(sel_data), .o_cycle_cnt(cycle_cnt), .o_state(state), .o_halted(halted)
  );

  function automatic logic [31:0] actual(input int f, input int idx);
    case (f)
      F_STATE:  return {30'b0, state};
      F_HALTED: return {31'b0, halted};
      F_VALID:  return {28'b0, ch_valid};
      F_DATA:   return ch_data[idx*DW +: DW];
      F_WCNT:   return {29'b0, ch_wcnt[idx*CW +: CW]};
      F_SEL:    return sel_data;
      F_CYC:    return cycle_cnt;
      default:  return 32'hXXXX_XXXX;
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [31:0] a;
      e = q.pop_front();
      a = actual(e.f, e.idx);
      n_total++;
      if (a === e.v) n_pass++;
      else $display("FAIL %s: got %h expected %h", e.name, a, e.v);
    end
  end

  task automatic expect_val(input string name, input int f, input int idx, input logic [31:0] v);
    exp_t e;
    e.name = name; e.f = f; e.idx = idx; e.v = v;
    q.push_back(e);
  endtask

  // One clock: drive at negedge+1, return at posedge+1 with the new register state visible
  task automatic cyc(input logic a, input logic c, input logic we,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] s);
    @(negedge clk); #1;
    if (!pc_hold) pc_val = pc_val + 32'd4;
    arm = a; clear = c; mem_we = we; mem_addr = addr; mem_wdata = wd; sel = s; pc = pc_val;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 32'hC8, 32'h5555, 0);
    expect_val("rst_state",  F_STATE,  0, 0);
    expect_val("rst_halted", F_HALTED, 0, 0);
    expect_val("rst_valid",  F_VALID,  0, 0);
    expect_val("rst_cyc",    F_CYC,    0, 0);
    expect_val("rst_ch0",    F_DATA,   0, 0);
    expect_val("rst_wcnt0",  F_WCNT,   0, 0);
    rst_n = 1'b1;

    // Writes in IDLE ignored, then arm, then an out-of-window write
    cyc(0, 0, 1, 32'hD4, 32'h1111, 0);
    expect_val("idle_wr_valid", F_VALID, 0, 0);
    expect_val("idle_wr_wcnt3", F_WCNT,  3, 0);
    expect_val("idle_state",    F_STATE, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    expect_val("arm_state", F_STATE, 0, 1);
    expect_val("arm_cyc",   F_CYC,   0, 0);
    cyc(0, 0, 1, 32'hD8, 32'h2222, 0);
    expect_val("oow_valid", F_VALID, 0, 0);
    expect_val("oow_wcnt3", F_WCNT,  3, 0);
    expect_val("oow_cyc",   F_CYC,   0, 1);

    // Basic captures
    cyc(0, 0, 1, 32'hC8, 32'hDEADBEEF, 0);
    expect_val("cap_ch0",   F_DATA,  0, 32'hDEADBEEF);
    expect_val("cap_valid", F_VALID, 0, 4'b0001);
    expect_val("cap_wcnt0", F_WCNT,  0, 1);
    expect_val("cap_sel0",  F_SEL,   0, 32'hDEADBEEF);
    expect_val("cap_cyc",   F_CYC,   0, 2);
    cyc(0, 0, 1, 32'hCB, 32'h12345678, 0);
    expect_val("lowbits_ch0",   F_DATA, 0, 32'h12345678);
    expect_val("lowbits_wcnt0", F_WCNT, 0, 2);
    cyc(0, 0, 1, 32'hD0, 32'h0000A5A5, 2);
    expect_val("cap_sel2",   F_SEL,   0, 32'h0000A5A5);
    expect_val("cap_valid2", F_VALID, 0, 4'b0101);
    expect_val("cap_cyc2",   F_CYC,   0, 4);

    // PC stall: 7 equal compares then a change keeps RUN
    pc_val = 32'h40; pc_hold = 1'b1;
    repeat (8) cyc(0, 0, 0, 0, 0, 0);
    expect_val("stall7_state", F_STATE, 0, 1);
    expect_val("stall7_cyc",   F_CYC,   0, 12);
    pc_hold = 1'b0;
    cyc(0, 0, 0, 0, 0, 0);
    expect_val("pcchg_state", F_STATE, 0, 1);
    expect_val("pcchg_cyc",   F_CYC,   0, 13);

    // 8th equal compare halts; a write in the same cycle is still captured
    pc_val = 32'h40; pc_hold = 1'b1;
    repeat (8) cyc(0, 0, 0, 0, 0, 0);
    expect_val("pre_halt_state", F_STATE, 0, 1);
    cyc(0, 0, 1, 32'hD4, 32'h0000CAFE, 3);
    expect_val("halt_state",  F_STATE,  0, 2);
    expect_val("halt_halted", F_HALTED, 0, 1);
    expect_val("halt_ch3",    F_DATA,   3, 32'h0000CAFE);
    expect_val("halt_valid",  F_VALID,  0, 4'b1101);
    expect_val("halt_wcnt3",  F_WCNT,   3, 1);
    expect_val("halt_cyc",    F_CYC,    0, 22);

    // Write in HALTED ignored; re-arm keeps captures
    cyc(0, 0, 1, 32'hCC, 32'h9999, 1);
    expect_val("hwr_ch1",   F_DATA,  1, 0);
    expect_val("hwr_valid", F_VALID, 0, 4'b1101);
    expect_val("hwr_wcnt1", F_WCNT,  1, 0);
    expect_val("hwr_cyc",   F_CYC,   0, 22);
    pc_hold = 1'b0;
    cyc(1, 0, 0, 0, 0, 0);
    expect_val("rearm_state", F_STATE, 0, 1);
    expect_val("rearm_cyc",   F_CYC,   0, 22);
    cyc(0, 0, 1, 32'hCC, 32'h1, 1);
    expect_val("rearm_ch1",   F_DATA,  1, 32'h1);
    expect_val("rearm_sel1",  F_SEL,   0, 32'h1);
    expect_val("rearm_valid", F_VALID, 0, 4'b1111);
    expect_val("rearm_ch0",   F_DATA,  0, 32'h12345678);
    expect_val("rearm_wcnt0", F_WCNT,  0, 2);
    expect_val("rearm_cyc",   F_CYC,   0, 23);

    // Counter saturation (3-bit counter saturates at 7)
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 32'hCC, 32'h100 + i, 1);
    expect_val("sat_wcnt1", F_WCNT, 1, 7);
    expect_val("sat_ch1",   F_DATA, 1, 32'h106);
    expect_val("sat_cyc",   F_CYC,  0, 30);

    // Halt again, then clear+arm together
    pc_val = 32'h40; pc_hold = 1'b1;
    repeat (9) cyc(0, 0, 0, 0, 0, 0);
    expect_val("halt2_state", F_STATE, 0, 2);
    expect_val("halt2_cyc",   F_CYC,   0, 39);
    cyc(0, 0, 0, 0, 0, 5);
    expect_val("sel5_halted", F_SEL, 0, 0);
    cyc(1, 1, 0, 0, 0, 5);
    expect_val("clr_state",  F_STATE,  0, 0);
    expect_val("clr_halted", F_HALTED, 0, 0);
    expect_val("clr_valid",  F_VALID,  0, 0);
    expect_val("clr_ch0",    F_DATA,   0, 0);
    expect_val("clr_wcnt1",  F_WCNT,   1, 0);
    expect_val("clr_cyc",    F_CYC,    0, 0);
    pc_hold = 1'b0;
    cyc(0, 0, 0, 0, 0, 0);
    expect_val("clr_sel0", F_SEL, 0, 0);

    // Reset mid-RUN with all channels valid
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'hC8, 32'h10, 0);
    cyc(0, 0, 1, 32'hCC, 32'h11, 0);
    cyc(0, 0, 1, 32'hD0, 32'h12, 0);
    cyc(0, 0, 1, 32'hD4, 32'h13, 3);
    expect_val("full_valid", F_VALID, 0, 4'b1111);
    expect_val("full_ch3",   F_DATA,  3, 32'h13);
    expect_val("full_cyc",   F_CYC,   0, 4);
    rst_n = 1'b0;
    cyc(1, 0, 1, 32'hC8, 32'hFF, 3);
    expect_val("mrst_state",  F_STATE,  0, 0);
    expect_val("mrst_halted", F_HALTED, 0, 0);
    expect_val("mrst_valid",  F_VALID,  0, 0);
    expect_val("mrst_ch0",    F_DATA,   0, 0);
    expect_val("mrst_ch3",    F_DATA,   3, 0);
    expect_val("mrst_wcnt0",  F_WCNT,   0, 0);
    expect_val("mrst_sel3",   F_SEL,    0, 0);
    expect_val("mrst_cyc",    F_CYC,    0, 0);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    expect_val("post_rst_state", F_STATE, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
